da_bitslice_sequencer: RTL
==========================

# da_bitslice_sequencer

Parametrised bit-serial input stage for the distributed-arithmetic FIR datapath. It accepts one parallel snapshot of TAPS samples per transaction and streams the samples LSB-first, one bit-slice per beat, as TAPS-bit ROM address vectors. It adds a valid/ready handshake on both sides, a bit counter with first/last (sign) markers, and downstream stall support. It sits between the sample delay line and the DA ROM/accumulator.

## Interface
- TAPS, 64: number of taps; must be a multiple of GROUP.
- DATA_W, 16: sample width in bits, two's complement; minimum 2.
- GROUP, 8: taps per DA ROM address group.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data holds a new snapshot.
- in_ready  out  1  block can accept a snapshot this cycle.
- in_data  in  TAPS*DATA_W  tap i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  out_bits holds a valid slice.
- out_ready  in  1  downstream accepts the slice this cycle.
- out_bits  out  TAPS  bit b of every tap; ROM group g reads [g*GROUP +: GROUP].
- out_first  out  1  current slice is bit 0; accumulator clears.
- out_last  out  1  current slice is bit DATA_W-1 (sign); accumulator subtracts.

## Operation
- State: IDLE, SHIFT. Bit counter cnt has width clog2(DATA_W).
- IDLE: in_ready=1, out_valid=0. When in_valid=1, the bank loads in_data, cnt is set to 0, and the block enters SHIFT.
- SHIFT: out_valid=1 and out_bits[i]=bank[i][0]. A beat completes when out_valid && out_ready.
- On each completed beat: every bank word shifts right by one (zero fill) and cnt increments.
- On a completed beat with cnt==DATA_W-1, the next state follows Configuration.
- out_first = SHIFT && cnt==0. out_last = SHIFT && cnt==DATA_W-1.
- out_ready=0: the bank, cnt, out_bits and markers all hold. There is no timeout.
- in_data is sampled only in the cycle the input handshake occurs.

## Timing
- Reset: in the cycle after an edge with resetn=0, the block is in IDLE, cnt=0, bank=0, shadow empty, out_valid=0, out_first=0, out_last=0, out_bits=0, in_ready=1.
- Latency: out_valid rises on the cycle after the input handshake. out_bits and the markers are registered-derived, with no combinational path from the inputs.
- A snapshot produces exactly DATA_W beats. Throughput without stalls is DATA_W+1 cycles per sample (macro undefined) or DATA_W cycles per sample (macro defined).
- in_valid is ignored while in_ready=0. in_valid is not required to stay high.
- Reset mid-SHIFT aborts the transaction. The in-flight slice is dropped and no out_last is issued.

## Configuration
- DA_SEQ_DOUBLE_BUFFER_EN undefined:
  - in_ready = (state==IDLE).
  - The final beat returns the block to IDLE.
- DA_SEQ_DOUBLE_BUFFER_EN defined: adds a shadow register of TAPS*DATA_W bits plus a shadow_full flag.
  - in_ready = !shadow_full.
  - An input accepted in IDLE goes directly to the bank.
  - An input accepted in SHIFT goes to the shadow, except on the final completed beat.
  - Final completed beat with shadow_full=1: bank<=shadow, shadow_full<=0, cnt<=0, stay in SHIFT.
  - Final completed beat with shadow_full=0 and a concurrent input handshake: bank<=in_data (bypass), cnt<=0, stay in SHIFT.
  - Final completed beat with neither: go to IDLE.
  - Reset clears shadow_full.

## Structure
- Package da_pkg holds:
  - the state enum {IDLE, SHIFT};
  - the CNT_W = $clog2(DATA_W) helper function;
  - the TAPS % GROUP == 0 elaboration check.
- Sub-module tap_shift_reg: one DATA_W-bit right shift register with load, shift enable and synchronous active-low reset. It is instantiated TAPS times in a generate loop. The top level owns the FSM, the counter and the shadow.

## Test plan
- Reset: resetn=0 for 2 cycles during in_valid=1. Required: out_valid=0, out_bits=0, in_ready=1 on the first cycle after release, and no load has occurred.
- Single tap (TAPS=8, DATA_W=4, GROUP=4, out_ready=1): tap0=4'b0101, others 0. Required: out_bits = 8'h01, 8'h00, 8'h01, 8'h00 on consecutive beats; out_first on beat 0 only; out_last on beat 3 only; IDLE afterwards.
- All-ones: every tap = 4'hF. Required: four beats of 8'hFF; group 1 sees 4'hF on each beat.
- Stall: out_ready=0 for 3 cycles at beat 1. Required: out_bits, cnt and markers hold across the stall; the total number of beats is still 4.
- Back-to-back: two snapshots offered continuously.
  - Macro undefined: a 1-cycle out_valid gap between the two samples.
  - Macro defined: 8 contiguous beats, with out_last at beats 3 and 7 and out_first at beats 0 and 4.
- Reset mid-SHIFT at beat 2, macro defined, shadow full. Required next cycle: out_valid=0, in_ready=1; no further beats from either snapshot.

Source files
------------

// File: rtl/da_pkg.sv
// Shared types and elaboration helpers for the distributed-arithmetic bit-slice sequencer.
package da_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width; a 1-bit floor keeps degenerate widths legal.
    function automatic int cnt_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

    function automatic bit taps_group_ok(input int taps, input int group);
        return (group > 0) && ((taps % group) == 0);
    endfunction

endpackage

// File: rtl/tap_shift_reg.sv
// One tap word of the sample bank: parallel load, LSB-first right shift with zero fill.
module tap_shift_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         lsb
);

    logic [W-1:0] q;

    // Load has priority so a reload on the final beat replaces the shifted word.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {1'b0, q[W-1:1]};
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/da_bitslice_sequencer.sv
// Bit-serial input stage for the DA FIR: streams TAPS samples LSB-first as ROM address slices.
// Optional DA_SEQ_DOUBLE_BUFFER_EN adds a shadow snapshot register for gap-free back-to-back samples.
module da_bitslice_sequencer
    import da_pkg::*;
#(
    parameter int TAPS   = 64,
    parameter int DATA_W = 16,
    parameter int GROUP  = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAPS*DATA_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TAPS-1:0]          out_bits,
    output logic                     out_first,
    output logic                     out_last
);

    localparam int              CNT_W    = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    if (!taps_group_ok(TAPS, GROUP)) begin : g_bad_group
        $error("da_bitslice_sequencer: TAPS must be a multiple of GROUP");
    end

    state_t                  state;
    state_t                  state_nx;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nx;
    logic                    beat;
    logic                    final_beat;
    logic                    in_fire;
    logic                    bank_load;
    logic                    bank_shift;
    logic [TAPS*DATA_W-1:0]  load_data;

`ifdef DA_SEQ_DOUBLE_BUFFER_EN
    logic [TAPS*DATA_W-1:0]  shadow;
    logic                    shadow_full;
    logic                    shadow_take;
    logic                    shadow_drain;

    assign in_ready = !shadow_full;
`else
    assign in_ready = (state == IDLE);
`endif

    // Outputs derive only from registers, so no input-to-output combinational path exists.
    assign out_valid  = (state == SHIFT);
    assign out_first  = out_valid && (cnt == '0);
    assign out_last   = out_valid && (cnt == CNT_LAST);
    assign beat       = out_valid && out_ready;
    assign final_beat = beat && (cnt == CNT_LAST);
    assign in_fire    = in_valid && in_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bank_load  = 1'b0;
        bank_shift = beat;
        load_data  = in_data;
`ifdef DA_SEQ_DOUBLE_BUFFER_EN
        shadow_take  = 1'b0;
        shadow_drain = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (in_fire) begin
                    bank_load = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
`ifdef DA_SEQ_DOUBLE_BUFFER_EN
                if (in_fire && !final_beat) begin
                    shadow_take = 1'b1;
                end
`endif
                if (beat) begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt_nx = '0;
`ifdef DA_SEQ_DOUBLE_BUFFER_EN
                        if (shadow_full) begin
                            bank_load    = 1'b1;
                            load_data    = shadow;
                            shadow_drain = 1'b1;
                        end else if (in_fire) begin
                            bank_load = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
`else
                        state_nx = IDLE;
`endif
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

`ifdef DA_SEQ_DOUBLE_BUFFER_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shadow_full <= 1'b0;
        end else if (shadow_take) begin
            shadow_full <= 1'b1;
        end else if (shadow_drain) begin
            shadow_full <= 1'b0;
        end
    end

    // NOTE: the shadow payload is not reset; shadow_full alone says whether it holds data.
    always_ff @(posedge clk) begin
        if (shadow_take) begin
            shadow <= in_data;
        end
    end
`endif

    for (genvar i = 0; i < TAPS; i++) begin : g_tap
        tap_shift_reg #(
            .W (DATA_W)
        ) u_tap (
            .clk    (clk),
            .resetn (resetn),
            .load   (bank_load),
            .shift  (bank_shift),
            .d      (load_data[i*DATA_W +: DATA_W]),
            .lsb    (out_bits[i])
        );
    end

endmodule
